hvac_actuator_guard: RTL and testbench
======================================

Name: hvac_actuator_guard

Overview:
- Sits directly downstream of the AC thermostat controller and consumes its heating/cooling decisions as requests.
- Drives the physical heater, compressor and fan, and enforces equipment-protection timing:
  - minimum on-time for each actuator;
  - dead time between heating and cooling modes;
  - compressor anti-short-cycle lockout;
  - fan run-on after each active period.
- Flags contradictory requests as a fault.

Parameters:
- MIN_ON, 8: minimum cycles heater_on or compressor_on stays high once asserted.
- MIN_OFF, 16: compressor lockout length, loaded when compressor_on falls.
- DEAD, 4: cycles with both actuators off between leaving HEAT or COOL and entering any mode.
- FAN_TAIL, 6: cycles fan_on stays high after an actuator falls.
- CW, 5: counter width. Must hold the largest parameter. All parameters are at least 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- heat_req, input, 1: heating request from the thermostat.
- cool_req, input, 1: cooling request from the thermostat.
- heater_on, output, 1: heater drive, registered.
- compressor_on, output, 1: compressor drive, registered.
- fan_on, output, 1: fan drive, registered.
- lockout, output, 1: high while the compressor anti-short-cycle timer is non-zero.
- fault, output, 1: registered; high the cycle after heat_req and cool_req are sampled both high.

Behaviour:
- Reset (rst sampled high at an edge):
  - state=IDLE; run, dead, lock and tail counters cleared to 0.
  - All outputs 0, including lockout, so cooling may start immediately after reset.
  - Reset mid-operation takes effect at that edge regardless of state or timers.
- Request decode:
  - hreq = heat_req & ~cool_req; creq = cool_req & ~heat_req.
  - conflict = heat_req & cool_req; treated as "no request".
  - fault <= conflict every cycle.
- States: IDLE, HEAT, COOL, DEAD. heater_on = (state==HEAT); compressor_on = (state==COOL). Both are registered, with a 1-cycle latency from request sample to output.
- IDLE:
  - hreq -> HEAT.
  - creq and lock==0 -> COOL.
  - creq and lock!=0 -> stay IDLE.
  - Otherwise stay IDLE.
- HEAT/COOL:
  - run=0 on entry; run increments each cycle in state, saturating.
  - Exit to DEAD only when run>=MIN_ON-1 and the own-mode request (hreq/creq) is low. This gives a minimum on-time of exactly MIN_ON cycles.
- On COOL exit: lock loads MIN_OFF.
- On any HEAT/COOL exit: tail loads FAN_TAIL and dead=0.
- DEAD:
  - Both actuators off. dead increments each cycle.
  - When dead==DEAD-1, transition using the IDLE rules (hreq -> HEAT, creq&lock==0 -> COOL, else IDLE). DEAD therefore lasts exactly DEAD cycles.
  - A mode switch produces a gap of exactly DEAD cycles between heater_on falling and compressor_on rising (or vice versa), unless lockout extends it.
- lock: decrements by 1 every cycle when non-zero and state!=COOL. lockout = (lock!=0). With cool_req held continuously, compressor_on stays low for exactly MIN_OFF+1 cycles.
- tail: decrements when non-zero. fan_on = (state==HEAT)|(state==COOL)|(tail!=0). Re-entering a mode during the tail keeps fan_on high with no glitch.
- Invariant: heater_on & compressor_on is never 1.
- Counters never wrap: run saturates at its maximum, and the others stop at 0.

Decomposition:
- Shared package/include hvac_pkg holds:
  - state encodings: IDLE=2'd0, HEAT=2'd1, COOL=2'd2, DEAD=2'd3;
  - default timing constants.
- One sub-module, hvac_down_counter (load, value, decrement-to-zero, zero flag, width CW), instantiated for lock and tail.
- The run and dead counters stay inline.

Test Plan:
1. Reset priority: rst=1 for 2 cycles with heat_req=1 -> all outputs 0. Release rst -> heater_on=1 one cycle after the first edge with rst=0.
2. Minimum on-time and fan tail: heat_req pulsed for 2 cycles from IDLE -> heater_on high exactly 8 cycles, then 4 cycles in DEAD. fan_on high 14 consecutive cycles.
3. Anti-short-cycle: cool_req high for 10 cycles, low for 2, then held high -> compressor_on falls after 10 cycles. lockout=1 for 16 cycles. compressor_on low for exactly 17 cycles, then re-asserts.
4. Mode switch: heat_req for 12 cycles, then cool_req immediately, with lock=0 -> heater_on falls, exactly 4 cycles with both off, then compressor_on=1. Both outputs are never high together in any cycle.
5. Conflict:
   - heat_req=cool_req=1 from IDLE -> fault=1 next cycle and every cycle held, no actuator on.
   - Same conflict 3 cycles into HEAT -> heater_on held until 8 cycles total, then off, fault=1 throughout.
6. Reset mid-COOL: rst asserted 5 cycles into COOL -> next cycle all outputs 0, lockout=0, fan_on=0. Then cool_req -> compressor_on=1 one cycle after rst release.

Source files
------------

// File: rtl/hvac_pkg.sv
// hvac_pkg: state encodings and default timing constants for the actuator guard
package hvac_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } state_t;
  localparam int DEF_MIN_ON = 8;
  localparam int DEF_MIN_OFF = 16;
  localparam int DEF_DEAD = 4;
  localparam int DEF_FAN_TAIL = 6;
  localparam int DEF_CW = 5;
endpackage

// File: rtl/hvac_down_counter.sv
// hvac_down_counter: loadable counter that decrements to zero and holds there
module hvac_down_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          zero
);
  logic [CW-1:0] value;
  assign zero = (value == '0);
  always_ff @(posedge clk)
    value <= rst ? '0 : load ? load_value : zero ? value : value - 1'b1;
endmodule

// File: rtl/hvac_actuator_guard.sv
// hvac_actuator_guard: enforces min-on, dead time, anti-short-cycle and fan run-on for HVAC actuators
module hvac_actuator_guard
  import hvac_pkg::*;
#(
  parameter int MIN_ON   = DEF_MIN_ON,
  parameter int MIN_OFF  = DEF_MIN_OFF,
  parameter int DEAD_LEN = DEF_DEAD,
  parameter int FAN_TAIL = DEF_FAN_TAIL,
  parameter int CW       = DEF_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic heat_req,
  input  logic cool_req,
  output logic heater_on,
  output logic compressor_on,
  output logic fan_on,
  output logic lockout,
  output logic fault
);
  localparam logic [CW-1:0] RUN_END = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_LEN - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(MIN_OFF);
  localparam logic [CW-1:0] TAIL_LOAD = CW'(FAN_TAIL);
  state_t state, state_n, pick;
  logic [CW-1:0] run, dead;
  logic hreq, creq, leave, lock_zero, tail_zero;
  assign hreq = heat_req & ~cool_req;
  assign creq = cool_req & ~heat_req;
  always_comb begin
    pick = hreq ? HEAT : (creq && lock_zero) ? COOL : IDLE;
    leave = (((state == HEAT) && !hreq) || ((state == COOL) && !creq)) && (run >= RUN_END);
    state_n = (state == IDLE) ? pick
            : (state == DEAD) ? ((dead == DEAD_END) ? pick : DEAD)
            : leave ? DEAD : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run <= '0;
      dead <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      run <= (state_n != state) ? '0 : ((state == HEAT || state == COOL) && !(&run)) ? run + 1'b1 : run;
      dead <= leave ? '0 : (state == DEAD && !(&dead)) ? dead + 1'b1 : dead;
      fault <= heat_req & cool_req;
    end
  end
  hvac_down_counter #(.CW(CW)) u_lock (
    .clk(clk),
    .rst(rst),
    .load(leave && state == COOL),
    .load_value(OFF_LOAD),
    .zero(lock_zero)
  );
  hvac_down_counter #(.CW(CW)) u_tail (
    .clk(clk),
    .rst(rst),
    .load(leave),
    .load_value(TAIL_LOAD),
    .zero(tail_zero)
  );
  assign heater_on = (state == HEAT);
  assign compressor_on = (state == COOL);
  assign fan_on = heater_on | compressor_on | ~tail_zero;
  assign lockout = ~lock_zero;
endmodule

// File: tb/tb_hvac_actuator_guard.sv
// tb_hvac_actuator_guard: directed vector table plus timed sequences for the actuator guard
module tb_hvac_actuator_guard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic heat_req = 1'b0;
  logic cool_req = 1'b0;
  logic heater_on, compressor_on, fan_on, lockout, fault;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic r;
    logic h;
    logic c;
    logic [4:0] e;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  hvac_actuator_guard dut (
    .clk(clk),
    .rst(rst),
    .heat_req(heat_req),
    .cool_req(cool_req),
    .heater_on(heater_on),
    .compressor_on(compressor_on),
    .fan_on(fan_on),
    .lockout(lockout),
    .fault(fault)
  );
  task automatic add(input logic r, input logic h, input logic c, input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) vq.push_back(vec_t'{r, h, c, e});
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0b%b) expected %0d (0b%b)", name, act, act[4:0], exp, exp[4:0]);
    end
  endtask
  task automatic step(input logic r, input logic h, input logic c);
    rst = r;
    heat_req = h;
    cool_req = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int gap, lk, n;
    add(1, 1, 0, 5'b00000, 2);
    add(0, 1, 0, 5'b10100, 1);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 1, 0, 5'b10100, 2);
    add(0, 0, 0, 5'b10100, 6);
    add(0, 0, 0, 5'b00100, 6);
    add(0, 0, 0, 5'b00000, 2);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 0, 1, 5'b01100, 10);
    add(0, 0, 0, 5'b00110, 2);
    add(0, 0, 1, 5'b00110, 4);
    add(0, 0, 1, 5'b00010, 10);
    add(0, 0, 1, 5'b00000, 1);
    add(0, 0, 1, 5'b01100, 2);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 1, 0, 5'b10100, 12);
    add(0, 0, 1, 5'b00100, 4);
    add(0, 0, 1, 5'b01100, 2);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 1, 1, 5'b00001, 3);
    add(0, 0, 0, 5'b00000, 1);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 1, 0, 5'b10100, 3);
    add(0, 1, 1, 5'b10101, 5);
    add(0, 1, 1, 5'b00101, 6);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 0, 0, 5'b00000, 1);
    add(1, 0, 0, 5'b00000, 1);
    add(0, 0, 1, 5'b01100, 5);
    add(1, 0, 1, 5'b00000, 1);
    add(0, 0, 1, 5'b01100, 1);
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].h, vq[i].c);
      check($sformatf("vec%0d {heater,comp,fan,lockout,fault}", i),
            int'({heater_on, compressor_on, fan_on, lockout, fault}), int'(vq[i].e));
      check($sformatf("vec%0d exclusive", i), int'(heater_on & compressor_on), 0);
    end
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    check("cool_before_switch", int'(compressor_on), 1);
    gap = 0;
    lk = 0;
    n = 0;
    step(0, 1, 0);
    while (!heater_on && n < 30) begin
      n++;
      if (!compressor_on) gap++;
      if (lockout) lk++;
      step(0, 1, 0);
    end
    check("cool_to_heat_gap", gap, 4);
    check("heater_after_gap", int'(heater_on), 1);
    while (lockout && n < 60) begin
      n++;
      lk++;
      check("exclusive_in_heat", int'(heater_on & compressor_on), 0);
      step(0, 1, 0);
    end
    check("lockout_length", lk, 16);
    check("heater_held", int'(heater_on), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
